// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file and its scoreboard.
// Ports: none (package). Provides default widths and the register-count helper.
// Imported by regfile_scoreboard and regfile_sb.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 2;

  // Every ADDR_W value names a register, so the file is always a full power of two.
  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending scoreboard: tracks registers owned by an in-flight multi-cycle producer.
// Ports: clk/reset; rsv_en/rsv_addr reserve; reg_wr_en/wr_addr write-back clear;
//        rs1/rs2_addr lookups -> rs1/rs2_pend; rsv_err (registered pulse); busy_any (OR of pending).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              reg_wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_pend,
  output logic              rs2_pend,
  output logic              rsv_err,
  output logic              busy_any
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                rsv_err_nxt;
  logic                rsv_is_zero;

  assign rsv_is_zero = (ZERO_REG != 0) && (rsv_addr == '0);

  // Reserve beats write-back: a new producer issuing in the same cycle owns the register.
  always_comb begin
    pending_nxt = pending;
    for (int i = 0; i < NUM_REGS; i++) begin
      if ((ZERO_REG != 0) && (i == 0)) begin
        pending_nxt[i] = 1'b0;
      end else if (rsv_en && (rsv_addr == ADDR_W'(i))) begin
        pending_nxt[i] = 1'b1;
      end else if (reg_wr_en && (wr_addr == ADDR_W'(i))) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // A reservation racing the clearing write-back is a clean hand-over, not an error.
  assign rsv_err_nxt = rsv_en && pending[rsv_addr] && !rsv_is_zero &&
                       !(reg_wr_en && (wr_addr == rsv_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      rsv_err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      rsv_err <= rsv_err_nxt;
    end
  end

  assign rs1_pend = pending[rs1_addr];
  assign rs2_pend = pending[rs2_addr];
  assign busy_any = |pending;

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: 2 combinational read ports, 1 synchronous write port, pending scoreboard.
// Ports: clk/reset; rs1/rs2_addr -> rs1/rs2_data, rs1/rs2_busy; wr_addr/wr_data/reg_wr_en write;
//        rsv_en/rsv_addr reserve; rsv_err reservation-on-pending pulse; busy_any any register pending.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              reg_wr_en,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              rsv_err,
  output logic              busy_any
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_ok;
  logic              rs1_pend;
  logic              rs2_pend;

  // Writes to the hardwired-zero register are dropped so storage never holds stale data there.
  assign wr_ok = reg_wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .reg_wr_en (reg_wr_en),
    .wr_addr   (wr_addr),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_pend  (rs1_pend),
    .rs2_pend  (rs2_pend),
    .rsv_err   (rsv_err),
    .busy_any  (busy_any)
  );

  // Read priority: hardwired zero, then same-cycle forwarded write (which also satisfies
  // the pending dependency), then storage.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs1_busy = rs1_pend;
    if ((ZERO_REG != 0) && (rs1_addr == '0)) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
    end else if ((BYPASS != 0) && reg_wr_en && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rs2_data = regs[rs2_addr];
    rs2_busy = rs2_pend;
    if ((ZERO_REG != 0) && (rs2_addr == '0)) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
    end else if ((BYPASS != 0) && reg_wr_en && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: three instances (bypass, no-bypass, zero-register) share stimulus.
// Ports: none. Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Ends with a one-line summary.
module tb_regfile_sb;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rs1_addr, rs2_addr, wr_addr, rsv_addr;
  logic [7:0] wr_data;
  logic       reg_wr_en, rsv_en;

  logic [7:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data, z_rs1_data, z_rs2_data;
  logic       a_rs1_busy, a_rs2_busy, a_rsv_err, a_busy_any;
  logic       b_rs1_busy, b_rs2_busy, b_rsv_err, b_busy_any;
  logic       z_rs1_busy, z_rs2_busy, z_rsv_err, z_busy_any;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(a_rs1_data), .rs2_data(a_rs2_data), .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_wr_en(reg_wr_en),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(a_rsv_err), .busy_any(a_busy_any));

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data), .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_wr_en(reg_wr_en),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(b_rsv_err), .busy_any(b_busy_any));

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1), .BYPASS(1)) u_z (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(z_rs1_data), .rs2_data(z_rs2_data), .rs1_busy(z_rs1_busy), .rs2_busy(z_rs2_busy),
    .wr_addr(wr_addr), .wr_data(wr_data), .reg_wr_en(reg_wr_en),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_err(z_rsv_err), .busy_any(z_busy_any));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; rs1_addr = '0; rs2_addr = '0; wr_addr = '0; rsv_addr = '0;
    wr_data = '0; reg_wr_en = 1'b0; rsv_en = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_rs1_data", 32'(a_rs1_data), 32'h00);
    check("rst_busy_any", 32'(a_busy_any), 32'h0);
    check("rst_rsv_err",  32'(a_rsv_err),  32'h0);

    // 1: write A5 to r2 and reserve r1, then async reset mid-cycle
    reg_wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'hA5; rsv_en = 1'b1; rsv_addr = 2'd1;
    step();
    reg_wr_en = 1'b0; rsv_en = 1'b0; rs1_addr = 2'd2;
    #1;
    check("t1_pre_data", 32'(a_rs1_data), 32'hA5);
    check("t1_pre_busy_any", 32'(a_busy_any), 32'h1);
    reset = 1'b1;
    #1;
    check("t1_rst_data", 32'(a_rs1_data), 32'h00);
    check("t1_rst_busy_any", 32'(a_busy_any), 32'h0);
    // write and reserve held across an edge while in reset: both must be discarded
    reg_wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h77; rsv_en = 1'b1; rsv_addr = 2'd3;
    step();
    reset = 1'b0; reg_wr_en = 1'b0; rsv_en = 1'b0; rs1_addr = 2'd3;
    #1;
    check("t1_rstwin_data", 32'(b_rs1_data), 32'h00);
    check("t1_rstwin_busy", 32'(a_busy_any), 32'h0);

    // 2: bypass vs. no bypass
    reg_wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'h3C; rs1_addr = 2'd3;
    #1;
    check("t2_byp_same", 32'(a_rs1_data), 32'h3C);
    check("t2_nobyp_same", 32'(b_rs1_data), 32'h00);
    step();
    reg_wr_en = 1'b0;
    #1;
    check("t2_nobyp_next", 32'(b_rs1_data), 32'h3C);
    check("t2_byp_next", 32'(a_rs1_data), 32'h3C);

    // 3: reserve r1, release by write-back three cycles later
    rsv_en = 1'b1; rsv_addr = 2'd1; rs2_addr = 2'd1;
    #1;
    check("t3_c0_busy", 32'(a_rs2_busy), 32'h0);
    step();
    rsv_en = 1'b0;
    #1;
    check("t3_c1_busy", 32'(a_rs2_busy), 32'h1);
    check("t3_c1_busy_any", 32'(a_busy_any), 32'h1);
    step();
    step();
    reg_wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h55;
    #1;
    check("t3_c3_byp_busy", 32'(a_rs2_busy), 32'h0);
    check("t3_c3_byp_data", 32'(a_rs2_data), 32'h55);
    check("t3_c3_nobyp_busy", 32'(b_rs2_busy), 32'h1);
    step();
    reg_wr_en = 1'b0;
    #1;
    check("t3_c4_busy", 32'(a_rs2_busy), 32'h0);
    check("t3_c4_data", 32'(a_rs2_data), 32'h55);
    check("t3_c4_busy_any", 32'(a_busy_any), 32'h0);

    // 4: reserve and write r2 together
    rsv_en = 1'b1; rsv_addr = 2'd2; reg_wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h11; rs1_addr = 2'd2;
    step();
    rsv_en = 1'b0; reg_wr_en = 1'b0;
    #1;
    check("t4_data", 32'(a_rs1_data), 32'h11);
    check("t4_pending", 32'(a_rs1_busy), 32'h1);
    check("t4_rsv_err", 32'(a_rsv_err), 32'h0);

    // 5: re-reserve pending r2 without a write
    rsv_en = 1'b1; rsv_addr = 2'd2;
    #1;
    check("t5_err_early", 32'(a_rsv_err), 32'h0);
    step();
    rsv_en = 1'b0;
    #1;
    check("t5_err_pulse", 32'(a_rsv_err), 32'h1);
    check("t5_pending", 32'(a_rs1_busy), 32'h1);
    step();
    check("t5_err_cleared", 32'(a_rsv_err), 32'h0);
    check("t5_pending_hold", 32'(a_rs1_busy), 32'h1);
    // re-reserve coinciding with the clearing write is a hand-over, not an error
    rsv_en = 1'b1; rsv_addr = 2'd2; reg_wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h22;
    step();
    rsv_en = 1'b0; reg_wr_en = 1'b0;
    #1;
    check("t5_handover_err", 32'(a_rsv_err), 32'h0);
    check("t5_handover_pend", 32'(a_rs1_busy), 32'h1);
    check("t5_handover_data", 32'(a_rs1_data), 32'h22);
    reg_wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h22;
    step();
    reg_wr_en = 1'b0;
    #1;
    check("t5_drain_busy_any", 32'(a_busy_any), 32'h0);

    // 6: hardwired zero register
    rs1_addr = 2'd0; reg_wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFF; rsv_en = 1'b1; rsv_addr = 2'd0;
    #1;
    check("t6_same_data", 32'(z_rs1_data), 32'h00);
    check("t6_same_busy", 32'(z_rs1_busy), 32'h0);
    step();
    reg_wr_en = 1'b0;
    #1;
    check("t6_data", 32'(z_rs1_data), 32'h00);
    check("t6_busy", 32'(z_rs1_busy), 32'h0);
    check("t6_busy_any", 32'(z_busy_any), 32'h0);
    check("t6_ref_data", 32'(a_rs1_data), 32'hFF);
    check("t6_ref_busy", 32'(a_rs1_busy), 32'h1);
    step();
    rsv_en = 1'b0;
    #1;
    check("t6_rsv_err", 32'(z_rsv_err), 32'h0);
    check("t6_ref_rsv_err", 32'(a_rsv_err), 32'h1);
    check("t6_busy_any_end", 32'(z_busy_any), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
